mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 6, word-address width of the shared RAM (64 words).
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch read request.
- i_adr  in  32  fetch byte address.
- i_ready  out  1  fetch request accepted this cycle.
- i_rdata  out  32  fetch read data.
- i_valid  out  1  i_rdata valid (1-cycle pulse).
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_adr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ready  out  1  data request accepted this cycle.
- d_rdata  out  32  data read data.
- d_valid  out  1  d_rdata valid (1-cycle pulse, reads only).
- err  out  1  bad-address pulse for the accepted request.
- m_en  out  1  RAM access enable.
- m_we  out  1  RAM write enable.
- m_adr  out  AW  RAM word address.
- m_wdata  out  32  RAM write data.
- m_rdata  in  32  RAM read data, valid the cycle after m_en & !m_we.

Function
REQ-003 At most one request SHALL be accepted per cycle; accept = req & ready; ready is combinational from the requests and last_grant.
REQ-004 Only D requesting: d_ready=1. Only I requesting: i_ready=1.
REQ-005 Both requesting: grant the port not granted last (round-robin); last_grant SHALL update on every accept.
REQ-006 A requester SHALL hold req, adr, we and wdata stable until accepted; the arbiter need not tolerate withdrawal before accept.
REQ-007 On an accept with a good address: m_en=1, m_adr=adr[AW+1:2], m_we=d_we for D and 0 for I, m_wdata=d_wdata; all combinational in the accept cycle.
REQ-008 Bad address is adr[1:0]!=0 or adr[31:AW+2]!=0. A bad request SHALL still be accepted, with m_en=0, err=1 in the accept cycle, and no valid pulse.
REQ-009 Read latency: the port's valid SHALL be 1 exactly one cycle after a good read accept, with rdata=m_rdata; otherwise valid=0.
REQ-010 FSM (state = access issued last cycle): IDLE, RSP_I, RSP_D, WR_D. Each cycle the next state follows that cycle's accept: I read -> RSP_I, D read -> RSP_D, D write -> WR_D, none or bad -> IDLE. Arbitration continues in every state, giving back-to-back throughput of 1 per cycle.
REQ-011 i_rdata and d_rdata SHALL hold their last delivered value when the corresponding valid=0.
REQ-012 Write followed by read to the same address on the next cycle SHALL return the new data; the RAM is read-after-write ordered.

Reset
REQ-013 While reset=0: state=IDLE, last_grant=I (D wins the first contention), i_valid=d_valid=0, i_rdata=d_rdata=0.
REQ-014 While reset=0: ready, err and m_en SHALL be 0.
REQ-015 Reset asserted with a read in flight SHALL drop the response; no valid pulse after reset is released.

Structure
REQ-016 FSM state encoding and grant encoding (GNT_I, GNT_D) SHALL live in the shared MIPS package, together with the AW default.
REQ-017 The block is one module, plus one sub-module rr_pick: combinational 2-way round-robin select from (i_req, d_req, last_grant) to (gnt_i, gnt_d).
REQ-018 The RAM is external; m_* connects to a 2^AW x 32 synchronous-read RAM.

Verification
REQ-019 After reset, i_req=d_req=1 held: grants alternate D,I,D,I; accepts occur in 4 consecutive cycles.
REQ-020 D write adr=0x10, wdata=0xDEADBEEF, then D read adr=0x10: m_adr=4, d_valid one cycle after accept, d_rdata=0xDEADBEEF.
REQ-021 I read adr=0x3 (misaligned): err=1 in the accept cycle, m_en=0, i_valid never pulses, FSM returns to IDLE.
REQ-022 D read adr=0x100 (AW=6, out of range): err=1, no RAM access; a following good read is served normally.
REQ-023 I read accepted, reset=0 asserted the next cycle before the response: i_valid=0 throughout; after release, outputs match reset values.
REQ-024 Only i_req=1 for 5 cycles, adr 0,4,8,12,16: i_valid pulses every cycle from cycle 2 with the matching RAM words.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the memory arbiter
package mem_arbiter_pkg;

  localparam int AW_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RSP_I = 2'd1,
    ST_RSP_D = 2'd2,
    ST_WR_D  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Misaligned, or beyond the 2^aw-word RAM window.
  function automatic logic adr_bad(input logic [31:0] adr, input int unsigned aw);
    return (adr[1:0] != 2'b00) || ((adr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - two-way round-robin grant select
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_req_i,
  input  logic   i_req_d,
  input  grant_t i_last_grant,
  output logic   o_gnt_i,
  output logic   o_gnt_d
);

  // On contention the port that did not win last time goes first.
  assign o_gnt_d = i_req_d & (~i_req_i | (i_last_grant == GNT_I));
  assign o_gnt_i = i_req_i & (~i_req_d | (i_last_grant == GNT_D));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data port arbiter onto one synchronous-read RAM
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_adr,
  output logic          i_ready,
  output logic [31:0]   i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_adr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic [31:0]   d_rdata,
  output logic          d_valid,
  output logic          err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  state_t      r_state;
  state_t      w_next;
  grant_t      r_last_grant;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;

  logic        w_gnt_i;
  logic        w_gnt_d;
  logic        w_acc_i;
  logic        w_acc_d;
  logic        w_acc;
  logic [31:0] w_adr;
  logic        w_bad;
  logic        w_good;

  rr_pick u_rr_pick (
    .i_req_i      (i_req),
    .i_req_d      (d_req),
    .i_last_grant (r_last_grant),
    .o_gnt_i      (w_gnt_i),
    .o_gnt_d      (w_gnt_d)
  );

  // Nothing is accepted while reset is held, even with requests pending.
  assign w_acc_i = w_gnt_i & reset;
  assign w_acc_d = w_gnt_d & reset;
  assign w_acc   = w_acc_i | w_acc_d;
  assign i_ready = w_acc_i;
  assign d_ready = w_acc_d;

  assign w_adr  = w_acc_d ? d_adr : i_adr;
  assign w_bad  = adr_bad(w_adr, AW);
  assign w_good = w_acc & ~w_bad;

  assign err     = w_acc & w_bad;
  assign m_en    = w_good;
  assign m_we    = w_good & w_acc_d & d_we;
  assign m_adr   = w_adr[AW+1:2];
  assign m_wdata = d_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = ST_IDLE;
    i_valid = 1'b0;
    d_valid = 1'b0;
    i_rdata = r_i_rdata;
    d_rdata = r_d_rdata;
    if (w_good) begin
      if (w_acc_i) begin
        w_next = ST_RSP_I;
      end else if (d_we) begin
        w_next = ST_WR_D;
      end else begin
        w_next = ST_RSP_D;
      end
    end
    // RAM data arrives the cycle after the read was issued.
    if (r_state == ST_RSP_I) begin
      i_valid = 1'b1;
      i_rdata = m_rdata;
    end
    if (r_state == ST_RSP_D) begin
      d_valid = 1'b1;
      d_rdata = m_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GNT_I;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_acc) begin
        r_last_grant <= w_acc_d ? GNT_D : GNT_I;
      end
      if (r_state == ST_RSP_I) begin
        r_i_rdata <= m_rdata;
      end
      if (r_state == ST_RSP_D) begin
        r_d_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a RAM stub
module tb_mem_arbiter;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [31:0]   i_adr;
  logic          i_ready;
  logic [31:0]   i_rdata;
  logic          i_valid;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_adr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          err;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  logic [31:0] ram [0:63];
  logic [31:0] ref_mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  bit          last_d;
  bit          exp_iv, exp_dv;
  logic [31:0] exp_ird, exp_drd;
  bit          acc_i, acc_d;
  logic        obs_ir, obs_dr, obs_iv, obs_dv, obs_err, obs_men;
  logic [31:0] obs_drd, obs_madr;
  int          iv_seen;

  mem_arbiter #(.AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_adr   (i_adr),
    .i_ready (i_ready),
    .i_rdata (i_rdata),
    .i_valid (i_valid),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_adr   (d_adr),
    .d_wdata (d_wdata),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .d_valid (d_valid),
    .err     (err),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) ram[m_adr] = m_wdata;
      else      m_rdata <= ram[m_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_d  = 1'b0;
    exp_iv  = 1'b0;
    exp_dv  = 1'b0;
    exp_ird = '0;
    exp_drd = '0;
  endtask

  task automatic do_cycle();
    bit gi, gd, bad, good;
    logic [31:0] adr;
    @(negedge clk);
    gi = 1'b0;
    gd = 1'b0;
    if (reset === 1'b1) begin
      if (i_req && d_req) begin
        if (last_d) gi = 1'b1; else gd = 1'b1;
      end else if (i_req) begin
        gi = 1'b1;
      end else if (d_req) begin
        gd = 1'b1;
      end
    end
    adr  = gd ? d_adr : i_adr;
    bad  = (gi || gd) && ((adr % 4) != 0 || adr >= 32'd256);
    good = (gi || gd) && !bad;
    obs_ir = i_ready; obs_dr = d_ready; obs_iv = i_valid; obs_dv = d_valid;
    obs_err = err; obs_men = m_en; obs_drd = d_rdata; obs_madr = 32'(m_adr);
    if (i_valid === 1'b1) iv_seen++;
    chk("i_ready", i_ready, gi);
    chk("d_ready", d_ready, gd);
    chk("err", err, bad);
    chk("m_en", m_en, good);
    if (good) begin
      chk("m_adr", m_adr, adr / 4);
      chk("m_we", m_we, gd && d_we);
      if (gd && d_we) chk("m_wdata", m_wdata, d_wdata);
    end
    chk("i_valid", i_valid, exp_iv);
    chk("d_valid", d_valid, exp_dv);
    chk("i_rdata", i_rdata, exp_ird);
    chk("d_rdata", d_rdata, exp_drd);
    @(posedge clk);
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    if (good) begin
      if (gd && d_we) begin
        ref_mem[adr / 4] = d_wdata;
      end else if (gd) begin
        exp_dv  = 1'b1;
        exp_drd = ref_mem[adr / 4];
      end else begin
        exp_iv  = 1'b1;
        exp_ird = ref_mem[adr / 4];
      end
    end
    if (gi || gd) last_d = gd;
    acc_i = gi;
    acc_d = gd;
    #1;
  endtask

  function automatic logic [31:0] rand_adr();
    if ($urandom_range(0, 5) == 0) return $urandom;
    return 32'($urandom_range(0, 63)) * 4;
  endfunction

  initial begin
    for (int k = 0; k < 64; k++) begin
      ram[k]     = $urandom;
      ref_mem[k] = ram[k];
    end
    m_rdata = '0;
    reset = 1'b0;
    i_req = 1'b1; i_adr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h24; d_wdata = '0;
    model_reset();
    iv_seen = 0;

    // Held in reset with both ports requesting.
    do_cycle();
    chk("rst_err", obs_err, 1'b0);
    chk("rst_men", obs_men, 1'b0);
    reset = 1'b1;

    // Contention: D first, then alternating.
    for (int k = 0; k < 4; k++) begin
      do_cycle();
      chk("rr_d", obs_dr, (k % 2) == 0);
      chk("rr_i", obs_ir, (k % 2) == 1);
    end
    i_req = 1'b0; d_req = 1'b0;
    do_cycle();

    // Write then read back the same word.
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h10; d_wdata = 32'hDEADBEEF;
    do_cycle();
    chk("wr_madr", obs_madr, 32'd4);
    d_we = 1'b0;
    do_cycle();
    chk("rd_madr", obs_madr, 32'd4);
    d_req = 1'b0;
    do_cycle();
    chk("raw_dv", obs_dv, 1'b1);
    chk("raw_data", obs_drd, 32'hDEADBEEF);

    // Misaligned fetch.
    i_req = 1'b1; i_adr = 32'h3;
    do_cycle();
    chk("mis_err", obs_err, 1'b1);
    chk("mis_men", obs_men, 1'b0);
    i_req = 1'b0;
    do_cycle();
    chk("mis_iv", obs_iv, 1'b0);

    // Out-of-range data read, then a good one.
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h100;
    do_cycle();
    chk("oor_err", obs_err, 1'b1);
    d_adr = 32'h8;
    do_cycle();
    chk("oor_next_err", obs_err, 1'b0);
    d_req = 1'b0;
    do_cycle();
    chk("oor_next_dv", obs_dv, 1'b1);

    // Fetch stream at 1 per cycle.
    iv_seen = 0;
    i_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_adr = 32'(k * 4);
      do_cycle();
    end
    i_req = 1'b0;
    do_cycle();
    chk("stream_pulses", iv_seen, 5);

    // Reset with a fetch response in flight.
    i_req = 1'b1; i_adr = 32'h40;
    do_cycle();
    reset = 1'b0;
    model_reset();
    do_cycle();
    chk("rst_drop_iv", obs_iv, 1'b0);
    i_req = 1'b0;
    reset = 1'b1;
    do_cycle();
    chk("post_rst_iv", obs_iv, 1'b0);
    do_cycle();

    // Randomized traffic with requesters holding until accepted.
    i_req = 1'b1; i_adr = rand_adr();
    d_req = 1'b1; d_we = 1'($urandom); d_adr = rand_adr(); d_wdata = $urandom;
    for (int k = 0; k < 400; k++) begin
      do_cycle();
      if (acc_i || !i_req) begin
        i_req = ($urandom_range(0, 3) != 0);
        i_adr = rand_adr();
      end
      if (acc_d || !d_req) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = 1'($urandom);
        d_adr   = rand_adr();
        d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    do_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
